step_sequencer_core: RTL and testbench

//  Sits directly downstream of the BPM step-pulse generator. Each 1-cycle Step pulse advances
//  a playhead over a NUM_STEPS x NUM_TRACKS on/off pattern, which the UI writes.
//  For every active cell at the new playhead, the block emits a per-track Trigger pulse and a

---
 rtl/step_sequencer_core.sv | 122 ++++++++++++
 tb/tb_step_sequencer_core.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer_core.sv
// Step sequencer: advances a playhead over an on/off pattern on each Step
// pulse and emits per-track Trigger pulses and fixed-length Gates.
`timescale 1ns/1ps
module step_sequencer_core #(
  parameter  int NUM_STEPS   = 16,
  parameter  int NUM_TRACKS  = 4,
  parameter  int GATE_CYCLES = 2500000,
  localparam int IDX_W = $clog2(NUM_STEPS),
  localparam int TW    = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
  localparam int GW    = $clog2(GATE_CYCLES + 1)
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  nStart,
  input  logic                  nStop,
  input  logic                  Step,
  input  logic [IDX_W:0]        Length,
  input  logic                  WrEn,
  input  logic [TW-1:0]         WrTrack,
  input  logic [IDX_W-1:0]      WrStep,
  input  logic                  WrData,
  output logic [IDX_W-1:0]      StepIndex,
  output logic                  Playing,
  output logic [NUM_TRACKS-1:0] Trigger,
  output logic [NUM_TRACKS-1:0] Gate
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_PLAY
  } state_t;

  localparam logic [IDX_W:0] LEN_MAX   = (IDX_W + 1)'(NUM_STEPS);
  localparam logic [TW:0]    NT_L      = (TW + 1)'(NUM_TRACKS);
  localparam logic [GW-1:0]  GATE_LOAD = GW'(GATE_CYCLES);

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_playing;
  logic [NUM_TRACKS-1:0]   r_trig;
  logic [GW-1:0]           r_cnt [NUM_TRACKS];
  logic [NUM_STEPS-1:0]    r_pat [NUM_TRACKS];

  logic [IDX_W:0]          w_len_eff;
  logic [IDX_W:0]          w_idx_inc;
  logic [IDX_W-1:0]        w_idx_next;
  logic [IDX_W-1:0]        w_fire_idx;
  logic                    w_adv;
  logic                    w_wr_ok;
  logic [NUM_TRACKS-1:0]   w_col;

  assign w_len_eff  = (Length == '0 || Length > LEN_MAX) ? LEN_MAX : Length;
  assign w_idx_inc  = {1'b0, r_idx} + 1'b1;
  assign w_idx_next = (w_idx_inc >= w_len_eff) ? '0 : w_idx_inc[IDX_W-1:0];
  // ARMED always plays step 0; PLAY moves to the wrapped successor
  assign w_fire_idx = (r_state == S_PLAY) ? w_idx_next : '0;
  assign w_adv      = Step && (r_state != S_IDLE);
  assign w_wr_ok    = WrEn && ({1'b0, WrTrack} < NT_L);

  always_comb begin
    w_col = '0;
    for (int t = 0; t < NUM_TRACKS; t++)
      w_col[t] = r_pat[t][w_fire_idx];
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_playing <= 1'b0;
      r_trig    <= '0;
      for (int t = 0; t < NUM_TRACKS; t++)
        r_cnt[t] <= '0;
    end else begin
      r_trig <= '0;
      for (int t = 0; t < NUM_TRACKS; t++)
        if (r_cnt[t] != '0)
          r_cnt[t] <= r_cnt[t] - GW'(1);
      if (!nStop) begin
        r_state   <= S_IDLE;
        r_playing <= 1'b0;
        for (int t = 0; t < NUM_TRACKS; t++)
          r_cnt[t] <= '0;
      end else if (!nStart) begin
        r_state   <= S_ARMED;
        r_playing <= 1'b0;
        r_idx     <= '0;
      end else if (w_adv) begin
        r_state   <= S_PLAY;
        r_playing <= 1'b1;
        r_idx     <= w_fire_idx;
        r_trig    <= w_col;
        // retrigger reloads, so a held gate never dips low
        for (int t = 0; t < NUM_TRACKS; t++)
          if (w_col[t])
            r_cnt[t] <= GATE_LOAD;
      end
    end
  end

  // Trigger reads the pre-write cell, so a same-cycle write lands next pass
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int t = 0; t < NUM_TRACKS; t++)
        r_pat[t] <= '0;
    end else if (w_wr_ok) begin
      r_pat[WrTrack][WrStep] <= WrData;
    end
  end

  always_comb begin
    Gate = '0;
    for (int t = 0; t < NUM_TRACKS; t++)
      Gate[t] = (r_cnt[t] != '0);
  end

  assign StepIndex = r_idx;
  assign Playing   = r_playing;
  assign Trigger   = r_trig;

endmodule

// File: tb/tb_step_sequencer_core.sv
// Bench for step_sequencer_core: directed scenarios plus random traffic,
// all checked against a step-level behavioural model.
`timescale 1ns/1ps
module tb_step_sequencer_core;

  localparam int NS = 16;
  localparam int NT = 3;
  localparam int G  = 20;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       nStart = 1'b1;
  logic       nStop = 1'b1;
  logic       Step = 1'b0;
  logic [4:0] Length = 5'd16;
  logic       WrEn = 1'b0;
  logic [1:0] WrTrack = '0;
  logic [3:0] WrStep = '0;
  logic       WrData = 1'b0;
  logic [3:0] StepIndex;
  logic       Playing;
  logic [2:0] Trigger;
  logic [2:0] Gate;

  int checks = 0;
  int errors = 0;

  step_sequencer_core #(
    .NUM_STEPS(NS),
    .NUM_TRACKS(NT),
    .GATE_CYCLES(G)
  ) dut (
    .Clock(Clock),
    .nReset(nReset),
    .nStart(nStart),
    .nStop(nStop),
    .Step(Step),
    .Length(Length),
    .WrEn(WrEn),
    .WrTrack(WrTrack),
    .WrStep(WrStep),
    .WrData(WrData),
    .StepIndex(StepIndex),
    .Playing(Playing),
    .Trigger(Trigger),
    .Gate(Gate)
  );

  always #5 Clock = ~Clock;

  // Model: mode 0 stopped, 1 waiting for first step, 2 playing
  int       m_mode;
  int       m_idx;
  bit [2:0] m_trig;
  int       m_left [NT];
  bit       m_pat [NT][NS];

  function automatic void model_reset();
    m_mode = 0;
    m_idx  = 0;
    m_trig = '0;
    for (int t = 0; t < NT; t++) begin
      m_left[t] = 0;
      for (int s = 0; s < NS; s++) m_pat[t][s] = 1'b0;
    end
  endfunction

  function automatic void model_update();
    int eff;
    if (!nReset) begin
      model_reset();
      return;
    end
    m_trig = '0;
    if (!nStop) begin
      m_mode = 0;
      for (int t = 0; t < NT; t++) m_left[t] = 0;
    end else begin
      for (int t = 0; t < NT; t++)
        if (m_left[t] > 0) m_left[t]--;
      if (!nStart) begin
        m_mode = 1;
        m_idx  = 0;
      end else if (Step && m_mode != 0) begin
        if (m_mode == 2) begin
          eff = (Length == 0 || Length > NS) ? NS : int'(Length);
          m_idx = (m_idx + 1 >= eff) ? 0 : m_idx + 1;
        end
        m_mode = 2;
        for (int t = 0; t < NT; t++) begin
          m_trig[t] = m_pat[t][m_idx];
          if (m_trig[t]) m_left[t] = G;
        end
      end
    end
    if (WrEn && int'(WrTrack) < NT) m_pat[WrTrack][WrStep] = WrData;
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [2:0] g;
    for (int t = 0; t < NT; t++) g[t] = (m_left[t] > 0);
    return {4'(m_idx), m_mode == 2, m_trig, g};
  endfunction

  task automatic tick();
    @(posedge Clock);
    model_update();
    #1;
  endtask

  task automatic start_pulse();
    nStart = 1'b0;
    tick();
    nStart = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if (StepIndex !== 4'd0) begin
      errors++;
      $display("FAIL reset_idx: got %0d expected 0", StepIndex);
    end
    checks++;
    if (Playing !== 1'b0) begin
      errors++;
      $display("FAIL reset_playing: got %b expected 0", Playing);
    end
    checks++;
    if (Trigger !== 3'b000) begin
      errors++;
      $display("FAIL reset_trigger: got %b expected 000", Trigger);
    end
    checks++;
    if (Gate !== 3'b000) begin
      errors++;
      $display("FAIL reset_gate: got %b expected 000", Gate);
    end
    nReset = 1'b1;
  endtask

  task automatic test_basic_pattern();
    logic [10:0] got;
    int s;
    for (int k = 0; k < 4; k++) begin
      WrEn = 1'b1; WrTrack = 2'd0; WrStep = 4'(k * 4); WrData = 1'b1;
      tick();
    end
    WrEn = 1'b0;
    Length = 5'd16;
    start_pulse();
    for (int i = 0; i < 17; i++) begin
      Step = 1'b1;
      tick();
      Step = 1'b0;
      s = i % 16;
      checks++;
      if (StepIndex !== 4'(s) || Trigger[0] !== (s % 4 == 0)) begin
        errors++;
        $display("FAIL basic_step%0d: got idx %0d trig0 %b expected idx %0d trig0 %b",
                 i, StepIndex, Trigger[0], s, (s % 4 == 0));
      end
      repeat ($urandom_range(0, 2)) begin
        tick();
        got = {StepIndex, Playing, Trigger, Gate};
        checks++;
        if (got !== exp_vec()) begin
          errors++;
          $display("FAIL basic_gap: got %h expected %h", got, exp_vec());
        end
      end
    end
  endtask

  task automatic test_length();
    start_pulse();
    Length = 5'd5;
    for (int i = 0; i < 12; i++) begin
      Step = 1'b1;
      tick();
      checks++;
      if (StepIndex !== 4'(i % 5)) begin
        errors++;
        $display("FAIL len5_step%0d: got %0d expected %0d", i, StepIndex, i % 5);
      end
    end
    Step = 1'b0;
    Length = 5'd0;
    start_pulse();
    for (int i = 0; i < 17; i++) begin
      Step = 1'b1;
      tick();
      checks++;
      if (StepIndex !== 4'(i % 16)) begin
        errors++;
        $display("FAIL len0_step%0d: got %0d expected %0d", i, StepIndex, i % 16);
      end
    end
    Step = 1'b0;
    tick();
  endtask

  task automatic test_gate_hold();
    int drop;
    for (int s = 0; s < NS; s++) begin
      WrEn = 1'b1; WrTrack = 2'd2; WrStep = 4'(s); WrData = 1'b1;
      tick();
    end
    WrEn = 1'b0;
    start_pulse();
    Step = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (Gate[2] !== 1'b1 || Trigger[2] !== 1'b1) begin
        errors++;
        $display("FAIL gate_held%0d: got gate %b trig %b expected 1 1",
                 i, Gate[2], Trigger[2]);
      end
    end
    Step = 1'b0;
    drop = -1;
    for (int k = 1; k <= G + 5; k++) begin
      tick();
      if (drop < 0 && Gate[2] === 1'b0) drop = k;
    end
    checks++;
    if (drop != G) begin
      errors++;
      $display("FAIL gate_len: got drop at %0d expected %0d", drop, G);
    end
  endtask

  task automatic test_stop();
    logic [3:0] held;
    start_pulse();
    for (int i = 0; i < 3; i++) begin
      Step = 1'b1;
      tick();
    end
    Step = 1'b0;
    tick();
    held = StepIndex;
    checks++;
    if (Gate[2] !== 1'b1 || held !== 4'd2) begin
      errors++;
      $display("FAIL stop_pre: got gate %b idx %0d expected 1 2", Gate[2], held);
    end
    nStop = 1'b0;
    tick();
    nStop = 1'b1;
    checks++;
    if ({Gate, Trigger, Playing} !== 7'd0) begin
      errors++;
      $display("FAIL stop_now: got gate %b trig %b play %b expected 0",
               Gate, Trigger, Playing);
    end
    for (int i = 0; i < 4; i++) begin
      Step = 1'b1;
      tick();
      checks++;
      if (Trigger !== 3'b000 || Playing !== 1'b0 || StepIndex !== 4'd2) begin
        errors++;
        $display("FAIL stop_ignore%0d: got trig %b play %b idx %0d expected 000 0 2",
                 i, Trigger, Playing, StepIndex);
      end
    end
    Step = 1'b0;
  endtask

  task automatic test_write_collision();
    Length = 5'd16;
    start_pulse();
    for (int i = 0; i < 3; i++) begin
      Step = 1'b1;
      tick();
    end
    WrEn = 1'b1; WrTrack = 2'd1; WrStep = 4'd3; WrData = 1'b1;
    tick();
    WrEn = 1'b0;
    checks++;
    if (StepIndex !== 4'd3 || Trigger[1] !== 1'b0) begin
      errors++;
      $display("FAIL coll_same: got idx %0d trig1 %b expected 3 0", StepIndex, Trigger[1]);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 15) begin
        checks++;
        if (StepIndex !== 4'd3 || Trigger[1] !== 1'b1) begin
          errors++;
          $display("FAIL coll_next: got idx %0d trig1 %b expected 3 1",
                   StepIndex, Trigger[1]);
        end
      end
    end
    Step = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [10:0] got;
    Step = 1'b1;
    tick();
    tick();
    #3;
    nReset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({StepIndex, Playing, Trigger, Gate} !== 11'd0) begin
      errors++;
      $display("FAIL async_rst: got idx %0d play %b trig %b gate %b expected 0",
               StepIndex, Playing, Trigger, Gate);
    end
    #2;
    nReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (Playing !== 1'b0 || Trigger !== 3'b000) begin
        errors++;
        $display("FAIL async_ignore%0d: got play %b trig %b expected 0 000",
                 i, Playing, Trigger);
      end
    end
    Step = 1'b0;
    start_pulse();
    for (int i = 0; i < 16; i++) begin
      Step = 1'b1;
      tick();
      got = {StepIndex, Playing, Trigger, Gate};
      checks++;
      if (got !== exp_vec() || Trigger !== 3'b000) begin
        errors++;
        $display("FAIL async_cleared%0d: got %h expected %h", i, got, exp_vec());
      end
    end
    Step = 1'b0;
  endtask

  task automatic test_random();
    logic [10:0] got;
    for (int i = 0; i < 3000; i++) begin
      WrEn    = ($urandom % 4) == 0;
      WrTrack = 2'($urandom);
      WrStep  = 4'($urandom);
      WrData  = 1'($urandom);
      Step    = ($urandom % 3) == 0;
      nStart  = ($urandom % 60) != 0;
      nStop   = ($urandom % 90) != 0;
      if (($urandom % 50) == 0) Length = 5'($urandom);
      tick();
      got = {StepIndex, Playing, Trigger, Gate};
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL random%0d: got %h expected %h", i, got, exp_vec());
      end
    end
    WrEn = 1'b0; Step = 1'b0; nStart = 1'b1; nStop = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_pattern();
    test_length();
    test_gate_hold();
    test_stop();
    test_write_collision();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
